// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the register-file write-port
// controller.
//   NUM_REGS  : number of registers written by the initialization sweep
//   REG_IDX_W : width of a register index
//   DATA_W    : register data width
//   SP_INDEX  : stack-pointer register index
//   SP_INIT   : stack-pointer initial value (only used when the macro
//               REGFILE_SP_INIT_EN is defined)
//   state_t   : controller FSM states (INIT sweep, RUN arbitration)
package regfile_pkg;

  localparam int          NUM_REGS  = 32;
  localparam int          REG_IDX_W = 5;
  localparam int          DATA_W    = 32;
  localparam int          SP_INDEX  = 29;
  localparam logic [31:0] SP_INIT   = 32'h0000_0FFC;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

endpackage

// File: rtl/regfile_write_ctrl_arb.sv
// rr_arb2: two-requester round-robin arbiter.
//   clk, reset : clock, asynchronous active-low reset
//   req[1:0]   : request vector, bit 0 = requester A, bit 1 = requester B
//   advance    : a contested grant was taken this cycle; hand priority over
//   grant[1:0] : one-hot grant, combinational from req and the pointer
// The pointer names the requester that wins the next contested cycle and
// starts at A after reset.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr_b;

  // An uncontested request is granted outright; a contested one goes to
  // whichever requester the pointer favours.
  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = ptr_b ? 2'b10 : 2'b01;
    end else begin
      grant = req;
    end
  end

  // Priority flips only after a contested grant, so a lone requester never
  // steals the turn of the other one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_b <= 1'b0;
    end else if (advance) begin
      ptr_b <= ~ptr_b;
    end
  end

endmodule

// File: rtl/regfile_write_ctrl.sv
// regfile_write_ctrl: owner of the register file's single write port.
// After reset it sweeps every register (writing zero, or SP_INIT into the
// stack pointer when REGFILE_SP_INIT_EN is defined), then arbitrates the
// port round-robin between writeback requesters A (ALU) and B (load data).
//   clk, reset            : clock, asynchronous active-low reset
//   a_valid/a_reg/a_data  : requester A write request
//   a_ready               : requester A accepted this cycle
//   b_valid/b_reg/b_data  : requester B write request
//   b_ready               : requester B accepted this cycle
//   regW/writeReg/writeData : registered register-file write port
//   init_busy             : high while the initialization sweep runs
// Optional feature macro: REGFILE_SP_INIT_EN.
module regfile_write_ctrl #(
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int DATA_W   = regfile_pkg::DATA_W
`ifdef REGFILE_SP_INIT_EN
  ,
  parameter int                SP_INDEX = regfile_pkg::SP_INDEX,
  parameter logic [DATA_W-1:0] SP_INIT  = DATA_W'(regfile_pkg::SP_INIT)
`endif
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          a_valid,
  output logic                          a_ready,
  input  logic [regfile_pkg::REG_IDX_W-1:0] a_reg,
  input  logic [DATA_W-1:0]             a_data,
  input  logic                          b_valid,
  output logic                          b_ready,
  input  logic [regfile_pkg::REG_IDX_W-1:0] b_reg,
  input  logic [DATA_W-1:0]             b_data,
  output logic                          regW,
  output logic [regfile_pkg::REG_IDX_W-1:0] writeReg,
  output logic [DATA_W-1:0]             writeData,
  output logic                          init_busy
);

  import regfile_pkg::*;

  state_t               state;
  state_t               next_state;
  logic [REG_IDX_W-1:0] idx;
  logic                 sweep_last;
  logic [DATA_W-1:0]    sweep_data;
  logic [1:0]           req;
  logic [1:0]           grant;
  logic                 a_xfer;
  logic                 b_xfer;

  assign sweep_last = (idx == REG_IDX_W'(NUM_REGS - 1));
  assign init_busy  = (state == INIT);

  // Requests are masked during the sweep so nothing is granted until RUN.
  assign req = (state == RUN) ? {b_valid, a_valid} : 2'b00;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (&req),
    .grant   (grant)
  );

  // Value written to the register currently addressed by the sweep.
`ifdef REGFILE_SP_INIT_EN
  assign sweep_data = (idx == REG_IDX_W'(SP_INDEX)) ? SP_INIT : '0;
`else
  assign sweep_data = '0;
`endif

  assign a_xfer = a_valid && a_ready;
  assign b_xfer = b_valid && b_ready;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= INIT;
    end else begin
      state <= next_state;
    end
  end

  // Next state and handshake readies; readies only ever assert in RUN.
  always_comb begin
    next_state = state;
    a_ready    = 1'b0;
    b_ready    = 1'b0;
    case (state)
      INIT: begin
        if (sweep_last) begin
          next_state = RUN;
        end
      end
      RUN: begin
        a_ready = grant[0];
        b_ready = grant[1];
      end
      default: next_state = INIT;
    endcase
  end

  // Sweep counter and the registered write port. Writes to register 0 are
  // accepted but never enabled, which keeps register 0 at zero; idle RUN
  // cycles drop regW and leave index/data as they were.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx       <= '0;
      regW      <= 1'b0;
      writeReg  <= '0;
      writeData <= '0;
    end else begin
      case (state)
        INIT: begin
          regW      <= 1'b1;
          writeReg  <= idx;
          writeData <= sweep_data;
          idx       <= sweep_last ? '0 : idx + 1'b1;
        end
        RUN: begin
          if (a_xfer) begin
            regW      <= (a_reg != '0);
            writeReg  <= a_reg;
            writeData <= a_data;
          end else if (b_xfer) begin
            regW      <= (b_reg != '0);
            writeReg  <= b_reg;
            writeData <= b_data;
          end else begin
            regW <= 1'b0;
          end
        end
        default: regW <= 1'b0;
      endcase
    end
  end

endmodule

// File: doc/regfile_write_ctrl.md
# regfile_write_ctrl

Controller for the register file's single write port. After reset it runs an initialization sweep that writes every register, then shares the write port between two writeback requesters (A: ALU result, B: load data) using valid/ready handshakes and round-robin arbitration. It sits between the execute/memory stages and the register file, driving `regW`, `writeReg` and `writeData`.

## Interface
- `NUM_REGS`, 32: number of registers swept during initialization.
- `DATA_W`, 32: data width.
- `SP_INDEX`, 29: index of the stack-pointer register.
- `SP_INIT`, 32'h00000FFC: stack-pointer initial value; used only when `REGFILE_SP_INIT_EN` is defined.
- `clk`  in  1  Single clock. All state updates on the rising edge.
- `reset`  in  1  Asynchronous, active-low. `reset`=0 resets.
- `a_valid`  in  1  Requester A has a write pending.
- `a_ready`  out  1  Requester A's write is accepted this cycle.
- `a_reg`  in  5  Requester A destination index.
- `a_data`  in  DATA_W  Requester A write data.
- `b_valid`, `b_ready`, `b_reg`, `b_data`: same as requester A, for requester B.
- `regW`  out  1  Register-file write enable.
- `writeReg`  out  5  Register-file write index.
- `writeData`  out  DATA_W  Register-file write data.
- `init_busy`  out  1  High while the initialization sweep is in progress.

## Operation
- FSM states: INIT, RUN.
- **Reset (async).** State is INIT, sweep index is 0, round-robin pointer is A, `regW`/`writeReg`/`writeData` are 0, `init_busy` is 1.
- **INIT.**
  - Each cycle, register `regW`=1, `writeReg`=idx and `writeData`=0.
  - Exception: `SP_INDEX` gets `SP_INIT` when `REGFILE_SP_INIT_EN` is defined.
  - idx increments each cycle. After idx = NUM_REGS-1 is issued, the FSM moves to RUN.
  - `a_ready` and `b_ready` are 0 throughout INIT.
- **RUN.** `init_busy`=0. Arbitration is combinational on valids and the pointer:
  - Only A valid: `a_ready`=1.
  - Only B valid: `b_ready`=1.
  - Both valid: the requester named by the pointer gets ready, and the other sees ready=0 and must hold its valid, reg and data stable.
  - Neither valid: both readies are 0.
- A transfer is valid&&ready. On a transfer:
  - The outputs register `regW`=1, `writeReg`=reg, `writeData`=data.
  - The pointer moves to the other requester, but only when both were valid. A single-requester grant leaves the pointer unchanged.
- Writes to index 0 are accepted (ready=1, pointer updates as normal) but register `regW`=0. Register 0 stays zero.
- No transfer in a cycle: `regW`=0 next cycle. `writeReg`/`writeData` hold their previous values.
- Same destination from both requesters in one cycle: they are serialized in grant order, and the later grant's data is the final value.
- There is no buffering. At most one write is in flight.

## Timing
- Sweep length is exactly NUM_REGS cycles. RUN is entered on the edge that registers the last sweep write. `init_busy` falls on that same edge.
- The first `ready` can assert in the cycle after `init_busy` falls.
- Latency is 1 cycle: a transfer at edge N drives the write port during cycle N..N+1.
- All outputs are registered. The register file samples on the falling edge, so its inputs are stable a half-cycle before use.
- Reset asserted mid-sweep or mid-RUN: the controller returns asynchronously to the reset values, and the sweep restarts from index 0 after release.
- Pending requests are not retained across reset.
- Arbiter fairness: with both requesters continuously valid, grants alternate A,B,A,B, starting with A after reset.

## Configuration
- `REGFILE_SP_INIT_EN` defined: the sweep writes `SP_INIT` to `SP_INDEX` and 0 to all other registers.
- `REGFILE_SP_INIT_EN` undefined: the sweep writes 0 to every register, and `SP_INIT` is unused.

## Structure
- Package `regfile_pkg` holds:
  - constants `NUM_REGS`, `REG_IDX_W`=5, `DATA_W`, `SP_INDEX` and `SP_INIT`;
  - the FSM state enum (INIT, RUN).
- Sub-module `rr_arb2`: a two-requester round-robin arbiter containing the pointer flop.
  - Inputs: `req[1:0]`, `advance`.
  - Output: one-hot `grant[1:0]`.
  - The top level contains the FSM, the sweep counter and the output registers.

## Test plan
- **Reset release, macro defined:** 32 cycles of `regW`=1 with `writeReg` 0..31; data is 0 except `writeReg`=29 with 32'h00000FFC; `init_busy` falls on the 32nd edge.
- **Macro undefined:** the same sweep with all data 0.
- **A only** (a_reg=5, a_data=32'hDEADBEEF) in RUN: `a_ready`=1 that cycle; the next cycle shows `regW`=1, `writeReg`=5, `writeData`=32'hDEADBEEF.
- **Both valid for 4 cycles** (A reg 3, B reg 7): grant order is A,B,A,B and the write port shows indices 3,7,3,7. A loser that holds its valid is granted next.
- **A writes reg 0** with data 32'h1: `a_ready`=1 and the next-cycle `regW`=0. B writes reg 0 while A is idle: same behaviour.
- **Reset pulsed at sweep index 12:** outputs go to 0 and `init_busy` is 1 immediately; after release the sweep restarts at index 0 and runs a full 32 cycles.
